// File: rtl/minmax_tracker_pkg.sv
// Shared types and constants for the min/max window tracker.
// Holds the FSM state encoding and the signed 2-bit comparator result codes.
package minmax_pkg;

    // Tracker FSM: no open window, window filling, result waiting for consumer.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACC   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Comparator result codes: in1 > in2, in1 == in2, in1 < in2.
    localparam logic signed [1:0] CMP_GT = 2'sb01;
    localparam logic signed [1:0] CMP_EQ = 2'sb00;
    localparam logic signed [1:0] CMP_LT = 2'sb11;

endpackage

// File: rtl/minmax_tracker_if.sv
// Stream interface of the min/max window tracker.
// Handshake rule for both directions: a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge; a producer keeps
// valid and its payload stable until that transfer.
// Optional index fields exist only when MINMAX_IDX_EN is defined.
interface minmax_tracker_if #(
    parameter int CNT_W = 4
);
    // Sample input side
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;

    // Result output side
    logic [15:0]      out_max;
    logic [15:0]      out_min;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0] out_max_idx;
    logic [CNT_W-1:0] out_min_idx;

    // The tracker itself
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_max, out_min, out_count, out_valid,
        output out_max_idx, out_min_idx
    );

    // Whoever feeds samples and consumes results
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_max, out_min, out_count, out_valid,
        input  out_max_idx, out_min_idx
    );
`else
    // The tracker itself
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_max, out_min, out_count, out_valid
    );

    // Whoever feeds samples and consumes results
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_max, out_min, out_count, out_valid
    );
`endif

endinterface

// File: rtl/minmax_tracker_cmp.sv
// 16-bit unsigned magnitude comparator.
// Returns CMP_GT when in1 > in2, CMP_LT when in1 < in2, CMP_EQ otherwise.
module comparator
    import minmax_pkg::*;
(
    input  logic [15:0]       in1,
    input  logic [15:0]       in2,
    output logic signed [1:0] result
);

    // Unsigned compare: 0x8000 ranks above 0x7FFF.
    always_comb begin
        result = CMP_EQ;
        if (in1 > in2) begin
            result = CMP_GT;
        end else if (in1 < in2) begin
            result = CMP_LT;
        end
    end

endmodule

// File: rtl/minmax_tracker.sv
// Running max/min tracker over windows of WINDOW unsigned 16-bit samples.
// One registered result (max, min, count) per window on a valid/ready output.
// Magnitude decisions come from two comparator instances; ties never update,
// so the first occurrence of an extreme value wins.
// Optional feature: define MINMAX_IDX_EN to add the 0-based positions of the
// max and min within the window (out_max_idx / out_min_idx).
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WINDOW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    minmax_tracker_if.slave  bus,
    output state_t           dbg_state_o
);

    localparam int CNT_W = $clog2(WINDOW) + 1;

    // Elaboration-time parameter guards.
    if (DATA_W != 16) begin : g_bad_data_w
        $error("minmax_tracker: DATA_W must be 16 to match the comparator");
    end
    if (WINDOW < 2 || WINDOW > 65535) begin : g_bad_window
        $error("minmax_tracker: WINDOW must be within 2..65535");
    end

    // FSM state
    state_t state_q, state_d;

    // Working window registers
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Result registers, loaded only when the window closes
    logic [DATA_W-1:0] out_max_q;
    logic [DATA_W-1:0] out_min_q;
    logic [CNT_W-1:0]  out_cnt_q;

`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0]  max_idx_q, max_idx_d;
    logic [CNT_W-1:0]  min_idx_q, min_idx_d;
    logic [CNT_W-1:0]  out_max_idx_q;
    logic [CNT_W-1:0]  out_min_idx_q;
`endif

    logic              in_ready;
    logic              accept;
    logic              load_out;
    logic signed [1:0] cmp_max_res;
    logic signed [1:0] cmp_min_res;

    // New sample versus current max and current min
    comparator u_cmp_max (
        .in1    (bus.in_data),
        .in2    (max_q),
        .result (cmp_max_res)
    );

    comparator u_cmp_min (
        .in1    (bus.in_data),
        .in2    (min_q),
        .result (cmp_min_res)
    );

    // Input side is blocked only while a result waits for the consumer.
    assign in_ready = (state_q != S_HOLD);
    assign accept   = bus.in_valid & in_ready;

    // Next window contents: first sample seeds everything, later samples
    // replace the extremes only on a strict compare.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        cnt_d = cnt_q;
`ifdef MINMAX_IDX_EN
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
`endif
        if (accept) begin
            if (state_q == S_EMPTY) begin
                max_d = bus.in_data;
                min_d = bus.in_data;
                cnt_d = CNT_W'(1);
`ifdef MINMAX_IDX_EN
                max_idx_d = '0;
                min_idx_d = '0;
`endif
            end else begin
                if (cmp_max_res == CMP_GT) begin
                    max_d = bus.in_data;
`ifdef MINMAX_IDX_EN
                    max_idx_d = cnt_q;
`endif
                end
                if (cmp_min_res == CMP_LT) begin
                    min_d = bus.in_data;
`ifdef MINMAX_IDX_EN
                    min_idx_d = cnt_q;
`endif
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic; load_out marks the single cycle that closes a window.
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            S_EMPTY: begin
                // A flush without a sample is ignored: no empty results.
                if (accept) begin
                    if (bus.flush) begin
                        state_d  = S_HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_d  = S_ACC;
                    end
                end
            end
            S_ACC: begin
                // A sample arriving with flush is folded in before closing.
                if ((accept && (cnt_d == CNT_W'(WINDOW))) || bus.flush) begin
                    state_d  = S_HOLD;
                    load_out = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Working window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '0;
            cnt_q <= '0;
`ifdef MINMAX_IDX_EN
            max_idx_q <= '0;
            min_idx_q <= '0;
`endif
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            cnt_q <= cnt_d;
`ifdef MINMAX_IDX_EN
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
`endif
        end
    end

    // Result registers capture the closing window and stay put until the next close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_max_q <= '0;
            out_min_q <= '0;
            out_cnt_q <= '0;
`ifdef MINMAX_IDX_EN
            out_max_idx_q <= '0;
            out_min_idx_q <= '0;
`endif
        end else if (load_out) begin
            out_max_q <= max_d;
            out_min_q <= min_d;
            out_cnt_q <= cnt_d;
`ifdef MINMAX_IDX_EN
            out_max_idx_q <= max_idx_d;
            out_min_idx_q <= min_idx_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_max   = out_max_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_count = out_cnt_q;
`ifdef MINMAX_IDX_EN
    assign bus.out_max_idx = out_max_idx_q;
    assign bus.out_min_idx = out_min_idx_q;
`endif

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Testbench for minmax_tracker with WINDOW = 4.
// Reference model: window max/min/positions recomputed from the list of
// accepted samples with a plain scan (strict compare, first occurrence wins).
module tb_minmax_tracker;
    import minmax_pkg::*;

    localparam int WIN = 4;
    localparam int CW  = $clog2(WIN) + 1;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    minmax_tracker_if #(.CNT_W(CW)) bus ();

    minmax_tracker #(
        .DATA_W (16),
        .WINDOW (WIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Samples accepted into the currently open window
    logic [15:0] win_q[$];

    // Model results
    logic [15:0] m_max, m_min;
    int          m_cnt, m_maxi, m_mini;

    // Observed result snapshot
    logic [15:0]   o_max, o_min;
    logic [CW-1:0] o_cnt, o_maxi, o_mini;
    logic          o_timeout, o_valid_after, o_ready_after;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        win_q.delete();
    endtask

    // Offer one sample (optionally with flush) and hold it for one accepting edge.
    task automatic push(input logic [15:0] d, input logic fl);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout in_ready stuck at %b, wanted 1", bus.in_ready);
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.flush    = fl;
        win_q.push_back(d);
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.in_data  = 16'($urandom);
    endtask

    // Flush for one cycle with no sample offered.
    task automatic flush_idle();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    // Wait (bounded) for a result, snapshot it, then handshake it away.
    task automatic take();
        int n;
        n = 0;
        o_timeout = 1'b0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) o_timeout = 1'b1;
        o_max = bus.out_max;
        o_min = bus.out_min;
        o_cnt = bus.out_count;
`ifdef MINMAX_IDX_EN
        o_maxi = bus.out_max_idx;
        o_mini = bus.out_min_idx;
`else
        o_maxi = '0;
        o_mini = '0;
`endif
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        o_valid_after = bus.out_valid;
        o_ready_after = bus.in_ready;
    endtask

    // ---------------- reference model ----------------
    task automatic model_calc();
        m_cnt  = win_q.size();
        m_max  = win_q[0];
        m_min  = win_q[0];
        m_maxi = 0;
        m_mini = 0;
        for (int i = 1; i < win_q.size(); i++) begin
            if (win_q[i] > m_max) begin m_max = win_q[i]; m_maxi = i; end
            if (win_q[i] < m_min) begin m_min = win_q[i]; m_mini = i; end
        end
        win_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out_max !== 16'h0) begin tests_failed++; $display("FAIL reset_max got %h want 0", bus.out_max); end
        tests_run++; if (bus.out_min !== 16'h0) begin tests_failed++; $display("FAIL reset_min got %h want 0", bus.out_min); end
        tests_run++; if (bus.out_count !== CW'(0)) begin tests_failed++; $display("FAIL reset_count got %0d want 0", bus.out_count); end
        tests_run++; if (dbg_state !== S_EMPTY) begin tests_failed++; $display("FAIL reset_state got %0d want %0d", dbg_state, S_EMPTY); end
    endtask

    task automatic test_basic();
        push(16'h0010, 1'b0);
        push(16'hFFFF, 1'b0);
        push(16'h0000, 1'b0);
        push(16'h8000, 1'b0);
        // Result must be visible the cycle after the last accept.
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency out_valid got %b want 1", bus.out_valid); end
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_hold_ready got %b want 0", bus.in_ready); end
        take();
        win_q.delete();
        tests_run++; if (o_max !== 16'hFFFF) begin tests_failed++; $display("FAIL basic_max got %h want ffff", o_max); end
        tests_run++; if (o_min !== 16'h0000) begin tests_failed++; $display("FAIL basic_min got %h want 0000", o_min); end
        tests_run++; if (o_cnt !== CW'(4)) begin tests_failed++; $display("FAIL basic_count got %0d want 4", o_cnt); end
`ifdef MINMAX_IDX_EN
        tests_run++; if (o_maxi !== CW'(1)) begin tests_failed++; $display("FAIL basic_max_idx got %0d want 1", o_maxi); end
        tests_run++; if (o_mini !== CW'(2)) begin tests_failed++; $display("FAIL basic_min_idx got %0d want 2", o_mini); end
`endif
        tests_run++; if (o_valid_after !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop got %b want 0", o_valid_after); end
        tests_run++; if (o_ready_after !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_back got %b want 1", o_ready_after); end
    endtask

    task automatic test_ties();
        repeat (4) push(16'h1234, 1'b0);
        take();
        win_q.delete();
        tests_run++; if (o_max !== 16'h1234) begin tests_failed++; $display("FAIL ties_max got %h want 1234", o_max); end
        tests_run++; if (o_min !== 16'h1234) begin tests_failed++; $display("FAIL ties_min got %h want 1234", o_min); end
`ifdef MINMAX_IDX_EN
        tests_run++; if (o_maxi !== CW'(0)) begin tests_failed++; $display("FAIL ties_max_idx got %0d want 0", o_maxi); end
        tests_run++; if (o_mini !== CW'(0)) begin tests_failed++; $display("FAIL ties_min_idx got %0d want 0", o_mini); end
`endif
        // Unsigned ordering around the sign bit
        push(16'h7FFF, 1'b0);
        push(16'h8000, 1'b0);
        flush_idle();
        take();
        win_q.delete();
        tests_run++; if (o_max !== 16'h8000) begin tests_failed++; $display("FAIL unsigned_max got %h want 8000", o_max); end
        tests_run++; if (o_min !== 16'h7FFF) begin tests_failed++; $display("FAIL unsigned_min got %h want 7fff", o_min); end
        tests_run++; if (o_cnt !== CW'(2)) begin tests_failed++; $display("FAIL unsigned_count got %0d want 2", o_cnt); end
    endtask

    task automatic test_flush();
        // Flush with nothing open must not produce a result.
        bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty_valid got %b want 0", bus.out_valid); end
            tests_run++; if (dbg_state !== S_EMPTY) begin tests_failed++; $display("FAIL flush_empty_state got %0d want %0d", dbg_state, S_EMPTY); end
        end
        bus.flush = 1'b0;
        // Flush after two samples, no sample in the flush cycle
        push(16'd5, 1'b0);
        push(16'd3, 1'b0);
        flush_idle();
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_idle_valid got %b want 1", bus.out_valid); end
        take();
        win_q.delete();
        tests_run++; if (o_cnt !== CW'(2)) begin tests_failed++; $display("FAIL flush_idle_count got %0d want 2", o_cnt); end
        tests_run++; if (o_max !== 16'd5) begin tests_failed++; $display("FAIL flush_idle_max got %h want 5", o_max); end
        tests_run++; if (o_min !== 16'd3) begin tests_failed++; $display("FAIL flush_idle_min got %h want 3", o_min); end
        // Flush together with the third sample: the sample counts
        push(16'd5, 1'b0);
        push(16'd3, 1'b0);
        push(16'd9, 1'b1);
        take();
        win_q.delete();
        tests_run++; if (o_cnt !== CW'(3)) begin tests_failed++; $display("FAIL flush_with_count got %0d want 3", o_cnt); end
        tests_run++; if (o_max !== 16'd9) begin tests_failed++; $display("FAIL flush_with_max got %h want 9", o_max); end
        tests_run++; if (o_min !== 16'd3) begin tests_failed++; $display("FAIL flush_with_min got %h want 3", o_min); end
`ifdef MINMAX_IDX_EN
        tests_run++; if (o_maxi !== CW'(2)) begin tests_failed++; $display("FAIL flush_with_max_idx got %0d want 2", o_maxi); end
        tests_run++; if (o_mini !== CW'(1)) begin tests_failed++; $display("FAIL flush_with_min_idx got %0d want 1", o_mini); end
`endif
    endtask

    task automatic test_backpressure();
        push(16'h00AA, 1'b0);
        push(16'h1111, 1'b0);
        push(16'h0F0F, 1'b0);
        push(16'h2222, 1'b0);
        model_calc();
        // Offer new samples while the result is held; none may be taken.
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            bus.flush    = 1'($urandom_range(0, 1));
            #1;
            tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            step();
            tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid cyc %0d got %b want 1", i, bus.out_valid); end
            tests_run++; if (bus.out_max !== m_max) begin tests_failed++; $display("FAIL bp_max cyc %0d got %h want %h", i, bus.out_max, m_max); end
            tests_run++; if (bus.out_min !== m_min) begin tests_failed++; $display("FAIL bp_min cyc %0d got %h want %h", i, bus.out_min, m_min); end
            tests_run++; if (bus.out_count !== CW'(m_cnt)) begin tests_failed++; $display("FAIL bp_count cyc %0d got %0d want %0d", i, bus.out_count, m_cnt); end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        take();
        tests_run++; if (o_max !== m_max) begin tests_failed++; $display("FAIL bp_take_max got %h want %h", o_max, m_max); end
        tests_run++; if (o_valid_after !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_drop got %b want 0", o_valid_after); end
        tests_run++; if (o_ready_after !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_back got %b want 1", o_ready_after); end
        tests_run++; if (dbg_state !== S_EMPTY) begin tests_failed++; $display("FAIL bp_state got %0d want %0d", dbg_state, S_EMPTY); end
    endtask

    task automatic test_reset_mid();
        // Output registers still hold the previous (non-zero) result here.
        push(16'h4444, 1'b0);
        push(16'h0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_max !== 16'h0) begin tests_failed++; $display("FAIL rstmid_max got %h want 0", bus.out_max); end
        tests_run++; if (bus.out_min !== 16'h0) begin tests_failed++; $display("FAIL rstmid_min got %h want 0", bus.out_min); end
        tests_run++; if (bus.out_count !== CW'(0)) begin tests_failed++; $display("FAIL rstmid_count got %0d want 0", bus.out_count); end
        tests_run++; if (dbg_state !== S_EMPTY) begin tests_failed++; $display("FAIL rstmid_state got %0d want %0d", dbg_state, S_EMPTY); end
        win_q.delete();
        step();
        #2;
        rst_n = 1'b1;
        step();
        push(16'h0300, 1'b0);
        push(16'h0100, 1'b0);
        push(16'h0400, 1'b0);
        push(16'h0200, 1'b0);
        model_calc();
        take();
        tests_run++; if (o_cnt !== CW'(4)) begin tests_failed++; $display("FAIL rstmid_fresh_count got %0d want 4", o_cnt); end
        tests_run++; if (o_max !== m_max) begin tests_failed++; $display("FAIL rstmid_fresh_max got %h want %h", o_max, m_max); end
        tests_run++; if (o_min !== m_min) begin tests_failed++; $display("FAIL rstmid_fresh_min got %h want %h", o_min, m_min); end
    endtask

    task automatic test_back_to_back();
        int len;
        int mode;
        logic [15:0] d;
        for (int w = 0; w < 40; w++) begin
            len  = $urandom_range(1, WIN);
            mode = $urandom_range(0, 1);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) step();
                d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                push(d, (k == len - 1) && (len < WIN) && (mode == 1));
            end
            if (len < WIN && mode == 0) flush_idle();
            repeat ($urandom_range(0, 3)) step();
            model_calc();
            take();
            tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("FAIL rnd_timeout win %0d no result within bound", w); end
            tests_run++; if (o_max !== m_max) begin tests_failed++; $display("FAIL rnd_max win %0d got %h want %h", w, o_max, m_max); end
            tests_run++; if (o_min !== m_min) begin tests_failed++; $display("FAIL rnd_min win %0d got %h want %h", w, o_min, m_min); end
            tests_run++; if (o_cnt !== CW'(m_cnt)) begin tests_failed++; $display("FAIL rnd_count win %0d got %0d want %0d", w, o_cnt, m_cnt); end
`ifdef MINMAX_IDX_EN
            tests_run++; if (o_maxi !== CW'(m_maxi)) begin tests_failed++; $display("FAIL rnd_max_idx win %0d got %0d want %0d", w, o_maxi, m_maxi); end
            tests_run++; if (o_mini !== CW'(m_mini)) begin tests_failed++; $display("FAIL rnd_min_idx win %0d got %0d want %0d", w, o_mini, m_mini); end
`endif
            tests_run++; if (o_valid_after !== 1'b0) begin tests_failed++; $display("FAIL rnd_valid_drop win %0d got %b want 0", w, o_valid_after); end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, %0d checks done", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
